// File: rtl/mem_access_unit_if.sv
// Unified instruction/data memory bus between mem_access_unit (master) and the memory (slave).
interface mem_access_unit_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-port stage: turns decoder fetch/load/store strobes into req/ack bus accesses, holds IR and DR.
// Optional completion counters (fetch_cnt/data_cnt) are enabled by defining MEM_ACCESS_COUNT_EN.
module mem_access_unit #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16,
  parameter int TCW     = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [AW-1:0]        pc,
  input  logic [AW-1:0]        aluout,
  input  logic [DW-1:0]        wd,
  input  logic                 iord,
  input  logic                 irwrite,
  input  logic                 memwrite,
  input  logic                 rd_en,
  output logic                 stall,
  output logic [DW-1:0]        instr,
  output logic [DW-1:0]        data,
  output logic                 align_err,
  output logic                 timeout_err,
  mem_access_unit_if.master    bus,
  output logic [31:0]          fetch_cnt,
  output logic [31:0]          data_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    K_FETCH = 2'd0,
    K_LOAD  = 2'd1,
    K_STORE = 2'd2
  } kind_t;

  state_t        state_r;
  state_t        state_nx_s;
  kind_t         kind_r;
  kind_t         req_kind_s;
  logic          access_s;
  logic          misalign_s;
  logic          timeout_hit_s;
  logic          stall_s;
  logic [AW-1:0] req_addr_s;
  logic [TCW-1:0] tcnt_r;
  logic [DW-1:0] instr_r;
  logic [DW-1:0] data_r;
  logic          align_err_r;
  logic          timeout_err_r;
  logic          mem_req_r;
  logic          mem_we_r;
  logic [AW-1:0] mem_addr_r;
  logic [DW-1:0] mem_wdata_r;

  assign access_s      = irwrite | memwrite | rd_en;
  assign timeout_hit_s = (tcnt_r == TCW'(TIMEOUT - 1));

  // Request decode: store beats load beats fetch; a fetch always addresses from pc
  always_comb begin
    req_kind_s = K_FETCH;
    req_addr_s = pc;
    if (memwrite) begin
      req_kind_s = K_STORE;
      req_addr_s = iord ? aluout : pc;
    end else if (rd_en) begin
      req_kind_s = K_LOAD;
      req_addr_s = iord ? aluout : pc;
    end else begin
      req_kind_s = K_FETCH;
      req_addr_s = pc;
    end
    misalign_s = (req_addr_s[1:0] != 2'b00);
  end

  // Next-state and stall decode
  always_comb begin
    state_nx_s = state_r;
    stall_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (access_s) begin
          stall_s    = 1'b1;
          state_nx_s = misalign_s ? DONE : WAIT;
        end else begin
          stall_s    = 1'b0;
          state_nx_s = IDLE;
        end
      end
      WAIT: begin
        stall_s = 1'b1;
        if (bus.mem_ack || timeout_hit_s) begin
          state_nx_s = DONE;
        end else begin
          state_nx_s = WAIT;
        end
      end
      DONE: begin
        stall_s    = 1'b0;
        state_nx_s = IDLE;
      end
      default: begin
        stall_s    = 1'b0;
        state_nx_s = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Bus request, timeout counter, instruction/data registers and sticky error flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      kind_r        <= K_FETCH;
      tcnt_r        <= {TCW{1'b0}};
      instr_r       <= {DW{1'b0}};
      data_r        <= {DW{1'b0}};
      align_err_r   <= 1'b0;
      timeout_err_r <= 1'b0;
      mem_req_r     <= 1'b0;
      mem_we_r      <= 1'b0;
      mem_addr_r    <= {AW{1'b0}};
      mem_wdata_r   <= {DW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (access_s && !misalign_s) begin
            kind_r      <= req_kind_s;
            tcnt_r      <= {TCW{1'b0}};
            mem_req_r   <= 1'b1;
            mem_we_r    <= (req_kind_s == K_STORE);
            mem_addr_r  <= req_addr_s;
            mem_wdata_r <= wd;
          end else if (access_s) begin
            // Misaligned: no bus cycle; fetch/load targets become 0, a store is dropped
            align_err_r <= 1'b1;
            if (req_kind_s == K_FETCH) begin
              instr_r <= {DW{1'b0}};
            end else if (req_kind_s == K_LOAD) begin
              data_r <= {DW{1'b0}};
            end
          end
        end
        WAIT: begin
          if (bus.mem_ack) begin
            mem_req_r <= 1'b0;
            case (kind_r)
              K_FETCH: instr_r <= bus.mem_rdata;
              K_LOAD:  data_r  <= bus.mem_rdata;
              default: ;
            endcase
          end else if (timeout_hit_s) begin
            mem_req_r     <= 1'b0;
            timeout_err_r <= 1'b1;
            case (kind_r)
              K_FETCH: instr_r <= {DW{1'b0}};
              K_LOAD:  data_r  <= {DW{1'b0}};
              default: ;
            endcase
          end else begin
            tcnt_r <= tcnt_r + TCW'(1);
          end
        end
        DONE: begin
          mem_req_r <= 1'b0;
        end
        default: begin
          mem_req_r <= 1'b0;
        end
      endcase
    end
  end

  assign stall         = stall_s;
  assign instr         = instr_r;
  assign data          = data_r;
  assign align_err     = align_err_r;
  assign timeout_err   = timeout_err_r;
  assign bus.mem_req   = mem_req_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;

`ifdef MEM_ACCESS_COUNT_EN
  logic        done_s;
  kind_t       done_kind_s;
  logic [31:0] fetch_cnt_r;
  logic [31:0] data_cnt_r;

  // Completion detect: ack or timeout in WAIT, or a misaligned request in IDLE
  always_comb begin
    done_s      = 1'b0;
    done_kind_s = kind_r;
    case (state_r)
      IDLE: begin
        if (access_s && misalign_s) begin
          done_s      = 1'b1;
          done_kind_s = req_kind_s;
        end else begin
          done_s      = 1'b0;
          done_kind_s = kind_r;
        end
      end
      WAIT: begin
        if (bus.mem_ack || timeout_hit_s) begin
          done_s = 1'b1;
        end else begin
          done_s = 1'b0;
        end
      end
      default: begin
        done_s = 1'b0;
      end
    endcase
  end

  // Wrapping completion counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_cnt_r <= 32'd0;
      data_cnt_r  <= 32'd0;
    end else if (done_s) begin
      if (done_kind_s == K_FETCH) begin
        fetch_cnt_r <= fetch_cnt_r + 32'd1;
      end else begin
        data_cnt_r <= data_cnt_r + 32'd1;
      end
    end
  end

  assign fetch_cnt = fetch_cnt_r;
  assign data_cnt  = data_cnt_r;
`else
  assign fetch_cnt = 32'd0;
  assign data_cnt  = 32'd0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: random accesses against a transaction-level reference model.
module tb_mem_access_unit;
  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int TIMEOUT = 16;
  localparam int TCW     = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [AW-1:0] pc = '0;
  logic [AW-1:0] aluout = '0;
  logic [DW-1:0] wd = '0;
  logic          iord = 1'b0;
  logic          irwrite = 1'b0;
  logic          memwrite = 1'b0;
  logic          rd_en = 1'b0;
  logic          stall;
  logic [DW-1:0] instr;
  logic [DW-1:0] data;
  logic          align_err;
  logic          timeout_err;
  logic [31:0]   fetch_cnt;
  logic [31:0]   data_cnt;

  mem_access_unit_if #(.AW(AW), .DW(DW)) bus ();

  mem_access_unit #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT), .TCW(TCW)) dut (
    .clk         (clk),
    .reset       (reset),
    .pc          (pc),
    .aluout      (aluout),
    .wd          (wd),
    .iord        (iord),
    .irwrite     (irwrite),
    .memwrite    (memwrite),
    .rd_en       (rd_en),
    .stall       (stall),
    .instr       (instr),
    .data        (data),
    .align_err   (align_err),
    .timeout_err (timeout_err),
    .bus         (bus.master),
    .fetch_cnt   (fetch_cnt),
    .data_cnt    (data_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          stall_len;
    int          req_len;
    logic [31:0] addr;
    logic        we;
    logic        is_store;
    logic [31:0] wdata;
    logic [31:0] instr;
    logic [31:0] data;
    logic        aerr;
    logic        terr;
    logic [31:0] fcnt;
    logic [31:0] dcnt;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] m_instr = 32'd0;
  logic [31:0] m_data  = 32'd0;
  logic        m_aerr  = 1'b0;
  logic        m_terr  = 1'b0;
  logic [31:0] m_fcnt  = 32'd0;
  logic [31:0] m_dcnt  = 32'd0;

  // Memory responder controls
  int          resp_lat  = 0;
  logic [31:0] resp_data = 32'd0;
  int          wcnt = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, expv);
    end
  endfunction

  // Memory: acks after resp_lat extra wait cycles; random ack noise while idle
  always @(negedge clk) begin
    if (!bus.mem_req) begin
      wcnt = 0;
      bus.mem_ack   = ($urandom_range(0, 3) == 0);
      bus.mem_rdata = $urandom;
    end else begin
      bus.mem_ack   = (wcnt == resp_lat);
      bus.mem_rdata = (wcnt == resp_lat) ? resp_data : $urandom;
      wcnt++;
    end
  end

  // Monitor: measures each stall episode and bus activity, compares on completion
  int          run = 0;
  int          req_run = 0;
  logic        bus_seen = 1'b0;
  logic        unstable = 1'b0;
  logic [31:0] cap_addr;
  logic        cap_we;
  logic [31:0] cap_wdata;

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      run = 0; req_run = 0; bus_seen = 1'b0; unstable = 1'b0;
      exp_q.delete();
    end else begin
      if (bus.mem_req) begin
        if (!bus_seen) begin
          cap_addr = bus.mem_addr; cap_we = bus.mem_we; cap_wdata = bus.mem_wdata;
          bus_seen = 1'b1;
        end else if (bus.mem_addr !== cap_addr || bus.mem_we !== cap_we || bus.mem_wdata !== cap_wdata) begin
          unstable = 1'b1;
        end
        req_run++;
      end
      if (stall) begin
        run++;
      end else if (run > 0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_access", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("stall_cycles", run, e.stall_len);
          chk("req_cycles", req_run, e.req_len);
          if (e.req_len > 0) begin
            chk("mem_addr", cap_addr, e.addr);
            chk("mem_we", {31'd0, cap_we}, {31'd0, e.we});
            chk("bus_stable", {31'd0, unstable}, 32'd0);
            if (e.is_store) chk("mem_wdata", cap_wdata, e.wdata);
          end
          chk("instr", instr, e.instr);
          chk("data", data, e.data);
          chk("align_err", {31'd0, align_err}, {31'd0, e.aerr});
          chk("timeout_err", {31'd0, timeout_err}, {31'd0, e.terr});
          chk("fetch_cnt", fetch_cnt, e.fcnt);
          chk("data_cnt", data_cnt, e.dcnt);
        end
        run = 0; req_run = 0; bus_seen = 1'b0; unstable = 1'b0;
      end
    end
  end

  // Issue one decoder request (strb = {memwrite, rd_en, irwrite}) and predict its outcome
  task automatic run_txn(input logic [2:0] strb, input logic [31:0] p, input logic [31:0] a,
                         input logic [31:0] w, input logic io, input int lat, input logic [31:0] rd);
    exp_t        e;
    int          kind;
    logic [31:0] addr;
    logic [31:0] target;
    logic        done;
    kind = strb[2] ? 2 : (strb[1] ? 1 : 0);
    addr = (kind == 0) ? p : (io ? a : p);
    e.addr = addr; e.we = (kind == 2); e.is_store = (kind == 2); e.wdata = w;
    if (addr[1:0] != 2'b00) begin
      e.stall_len = 1; e.req_len = 0; m_aerr = 1'b1; target = 32'd0;
    end else if (lat <= TIMEOUT - 1) begin
      e.stall_len = lat + 2; e.req_len = lat + 1; target = rd;
    end else begin
      e.stall_len = TIMEOUT + 1; e.req_len = TIMEOUT; m_terr = 1'b1; target = 32'd0;
    end
    if (kind == 0) m_instr = target;
    else if (kind == 1) m_data = target;
`ifdef MEM_ACCESS_COUNT_EN
    if (kind == 0) m_fcnt = m_fcnt + 32'd1;
    else m_dcnt = m_dcnt + 32'd1;
`endif
    e.instr = m_instr; e.data = m_data; e.aerr = m_aerr; e.terr = m_terr;
    e.fcnt = m_fcnt; e.dcnt = m_dcnt;
    exp_q.push_back(e);

    pc = p; aluout = a; wd = w; iord = io;
    memwrite = strb[2]; rd_en = strb[1]; irwrite = strb[0];
    resp_lat = lat; resp_data = rd;
    done = 1'b0;
    for (int i = 0; i < TIMEOUT + 8 && !done; i++) begin
      @(negedge clk);
      if (!stall) done = 1'b1;
    end
    if (!done) chk("access_completes", 32'd0, 32'd1);
    @(posedge clk); #1;
    memwrite = 1'b0; rd_en = 1'b0; irwrite = 1'b0;
  endtask

  initial begin
    logic [31:0] p, a;
    int lat, gap;
    logic [2:0] strb;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_instr", instr, 32'd0);
    chk("rst_data", data, 32'd0);
    chk("rst_align_err", {31'd0, align_err}, 32'd0);
    chk("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
    chk("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
    chk("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_fetch_cnt", fetch_cnt, 32'd0);
    chk("rst_data_cnt", data_cnt, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Directed cases from the access timing rules
    run_txn(3'b001, 32'h40,  32'h0,   32'h0,        1'b0, 3,           32'h8C0A0004);
    run_txn(3'b010, 32'h44,  32'h200, 32'h0,        1'b1, 0,           32'hDEADBEEF);
    run_txn(3'b100, 32'h48,  32'h102, 32'h12345678, 1'b1, 0,           32'h0);
    run_txn(3'b001, 32'h80,  32'h0,   32'h0,        1'b0, TIMEOUT + 5, 32'h0);
    run_txn(3'b001, 32'h84,  32'h3,   32'h0,        1'b1, TIMEOUT - 1, 32'hCAFEF00D);
    run_txn(3'b100, 32'h88,  32'h300, 32'hA5A5A5A5, 1'b1, 2,           32'h0);

    // Reset in the second WAIT cycle of a fetch
    pc = 32'h90; iord = 1'b0; irwrite = 1'b1; resp_lat = 10; resp_data = 32'h11111111;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0; irwrite = 1'b0;
    #1;
    chk("rst_mid_mem_req", {31'd0, bus.mem_req}, 32'd0);
    chk("rst_mid_instr", instr, 32'd0);
    chk("rst_mid_timeout_err", {31'd0, timeout_err}, 32'd0);
    m_instr = 32'd0; m_data = 32'd0; m_aerr = 1'b0; m_terr = 1'b0; m_fcnt = 32'd0; m_dcnt = 32'd0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_stall", {31'd0, stall}, 32'd0);
    chk("post_rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
    run_txn(3'b001, 32'hA0, 32'h0, 32'h0, 1'b0, 1, 32'h22222222);

    // Randomized traffic
    for (int n = 0; n < 150; n++) begin
      strb = 3'($urandom_range(1, 7));
      p = $urandom; a = $urandom;
      if ($urandom_range(0, 3) != 0) p[1:0] = 2'b00;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      if ($urandom_range(0, 7) == 0) lat = $urandom_range(TIMEOUT - 1, TIMEOUT + 3);
      else lat = $urandom_range(0, 5);
      run_txn(strb, p, a, $urandom, 1'($urandom_range(0, 1)), lat, $urandom);
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        @(posedge clk); #1;
      end
    end

    repeat (3) @(posedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-port stage directly downstream of the multi-cycle main decoder.
- Converts the decoder's per-state memory controls (irwrite, memwrite, iord, plus a read strobe for the MEMRD state) into req/ack transactions on a unified instruction/data memory that has variable latency.
- Holds the instruction register and the data register.
- Asserts stall, which freezes decoder state advance and all datapath write enables until the access completes.

Parameters:
- AW, 32, memory address width.
- DW, 32, data width.
- TIMEOUT, 16, maximum WAIT cycles before an access is aborted (>=1).
- TCW, 5, width of the timeout counter (must hold TIMEOUT).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- pc  in  AW  instruction address.
- aluout  in  AW  data address.
- wd  in  DW  store data.
- iord  in  1  0 = address from pc, 1 = address from aluout.
- irwrite  in  1  fetch request, load instr.
- memwrite  in  1  store request.
- rd_en  in  1  data-load request, load data.
- stall  out  1  hold the decoder and datapath.
- instr  out  DW  instruction register.
- data  out  DW  data register.
- align_err  out  1  sticky misaligned-access flag.
- timeout_err  out  1  sticky timeout flag.
- mem_req  out  1  bus request.
- mem_we  out  1  bus write.
- mem_addr  out  AW  bus address.
- mem_wdata  out  DW  bus write data.
- mem_ack  in  1  bus acknowledge.
- mem_rdata  in  DW  bus read data.
- fetch_cnt  out  32  completed fetches (optional feature).
- data_cnt  out  32  completed loads and stores (optional feature).

Behaviour:
- Reset values:
  - state = IDLE.
  - instr = 0, data = 0.
  - align_err = 0, timeout_err = 0.
  - mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
  - Counters = 0.
- Reset is effective immediately, mid-transaction included: mem_req drops asynchronously and nothing is captured.
- access = irwrite | memwrite | rd_en.
- Address selection: iord ? aluout : pc.
  - irwrite always uses pc, whatever the value of iord.
- Request priority if several strobes are asserted together: memwrite > rd_en > irwrite.
  - The lower-priority strobe is ignored; the decoder never asserts more than one.
- stall = (state==IDLE & access) | state==WAIT. stall is combinational and is 0 in DONE.
- State machine:
  - IDLE & access, address aligned:
    - Latch the address, wdata, and mem_we = memwrite, plus the request kind.
    - Clear the timeout counter.
    - Go to WAIT.
  - IDLE & access, address[1:0] != 0:
    - No bus request is issued.
    - Set align_err.
    - For a fetch, instr <= 0 (nop); for a load, data <= 0; a store is suppressed.
    - Go to DONE.
  - WAIT:
    - mem_req = 1; mem_addr, mem_we and mem_wdata are held stable.
    - If mem_ack is sampled high: a fetch captures instr <= mem_rdata; a load captures data <= mem_rdata; a store captures nothing. Go to DONE.
    - Else, if the counter has reached TIMEOUT-1: set timeout_err, load 0 into the target register (fetch/load), go to DONE.
    - Otherwise, increment the counter.
  - DONE:
    - mem_req = 0; stall = 0, so the decoder advances on this edge.
    - A new request is never issued in DONE.
    - Go to IDLE unconditionally.
- mem_req deasserts in the cycle after the ack edge.
- mem_ack is ignored outside WAIT.
- Timing:
  - Minimum access: ack in the first WAIT cycle gives 2 stall cycles.
  - Each extra wait state adds one stall cycle.
  - A timed-out access gives TIMEOUT+1 stall cycles.
- instr and data change only at a capture edge; otherwise they hold.
- align_err and timeout_err clear only on reset.

Optional Feature:
- Macro: MEM_ACCESS_COUNT_EN.
- Defined:
  - fetch_cnt increments on each completed fetch: ack or timeout in WAIT, or a misaligned fetch in IDLE.
  - data_cnt increments on each completed load or store, by the same rule.
  - Both are 32-bit and wrap from 0xFFFFFFFF to 0.
- Not defined: both ports are driven constant 0 and no counter flops exist.

Test Plan:
- Fetch with 3 wait states: pc=0x40, irwrite=1, mem_rdata=0x8C0A0004, ack in the 4th WAIT cycle -> mem_addr=0x40, mem_we=0, stall high for 5 cycles, instr=0x8C0A0004, mem_req low the next cycle.
- Load: iord=1, rd_en=1, aluout=0x200, ack in the first WAIT cycle with 0xDEADBEEF -> stall high for 2 cycles, data=0xDEADBEEF, instr unchanged.
- Misaligned store: memwrite=1, iord=1, aluout=0x102 -> mem_req never rises, align_err=1, stall high for 1 cycle, then DONE.
- Timeout: TIMEOUT=16, fetch, no ack -> mem_req high for 16 cycles, timeout_err=1, instr=0, stall high for 17 cycles.
- Reset mid-access: reset low in the 2nd WAIT cycle -> mem_req=0 immediately, instr=0, state=IDLE after release, and a fresh fetch completes normally.
- Counters (macro defined): 3 fetches + 1 store + 1 load -> fetch_cnt=3, data_cnt=2. Macro undefined -> both read 0.
